// File: rtl/loader_pkg.sv
// Shared types and constants for the RAM program loader.
package loader_pkg;

    localparam int LOADER_RAM_BYTES_DEFAULT = 16;
    localparam int LOADER_LEN_MIN           = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_e;

endpackage

// File: rtl/loader_checksum.sv
// 8-bit modulo-256 running sum over the frame's data bytes, with a compare
// against the byte currently presented on the stream.
module loader_checksum
    import loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add_en,
    input  logic [7:0] add_data,
    input  logic [7:0] cmp_data,
    output logic       match
);

    logic [7:0] sum_q, sum_d;

    // Clear takes priority so a new frame always starts from zero.
    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = 8'h00;
        end else if (add_en) begin
            sum_d = sum_q + add_data;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign match = (sum_q == cmp_data);

endmodule

// File: rtl/ram_program_loader.sv
// Framed byte-stream loader that fills the CPU program RAM and holds the CPU
// in reset while loading. Frame: length N, N data bytes, and a trailing
// checksum byte when LOADER_CHECKSUM_EN is defined.
module ram_program_loader
    import loader_pkg::*;
#(
    parameter int RAM_BYTES = LOADER_RAM_BYTES_DEFAULT,
    parameter int ADDR_W    = $clog2(RAM_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    // One extra bit so a length of exactly RAM_BYTES fits.
    localparam int LEN_W = ADDR_W + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [LEN_W-1:0]  len_q, len_d;

    logic xfer;
    logic len_bad;
    logic last_byte;
    logic enter_len;

    assign xfer      = data_valid && data_ready;
    assign len_bad   = (data_in < 8'(LOADER_LEN_MIN)) || (data_in > 8'(RAM_BYTES));
    assign last_byte = ({1'b0, addr_q} == (len_q - LEN_W'(1)));
    assign enter_len = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                 (state_q == ST_ERR));

`ifdef LOADER_CHECKSUM_EN
    logic sum_match;

    loader_checksum u_checksum (
        .clk      (clk),
        .rst      (rst),
        .clr      (enter_len),
        .add_en   ((state_q == ST_DATA) && xfer),
        .add_data (data_in),
        .cmp_data (data_in),
        .match    (sum_match)
    );
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured outside an active frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (xfer) state_d = len_bad ? ST_ERR : ST_DATA;
            end
            ST_DATA: begin
                if (xfer) state_d = ST_WRITE;
            end
            ST_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
                state_d = last_byte ? ST_CHECK : ST_DATA;
`else
                state_d = last_byte ? ST_DONE : ST_DATA;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (xfer) state_d = sum_match ? ST_DONE : ST_ERR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        data_ready = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHECK);
        cpu_hold   = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_WRITE) ||
                     (state_q == ST_CHECK) || (state_q == ST_ERR);
        ram_we     = (state_q == ST_WRITE);
        done       = (state_q == ST_DONE);
        error      = (state_q == ST_ERR);
    end

    // Datapath: latch length, capture data on accept, advance address after each write.
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        len_d  = len_q;
        if ((state_q == ST_LEN) && xfer && !len_bad) begin
            len_d  = LEN_W'(data_in);
            addr_d = '0;
        end
        if ((state_q == ST_DATA) && xfer) begin
            data_d = data_in;
        end
        if (state_q == ST_WRITE) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= 8'h00;
            len_q  <= '0;
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
            len_q  <= len_d;
        end
    end

    assign ram_addr = addr_q;
    assign ram_data = data_q;

endmodule
